// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Single-issue instruction fetch stage in front of a synchronous instruction
// memory. The memory returns read data one cycle after it samples pc_addr.
// The stage therefore keeps one address "in flight" (if_pc / if_valid) whose
// data appears on mem_instr in the following cycle. When there is no stall,
// the stage delivers one instruction per cycle to decode.
//
// Optional feature (compile-time macro FETCH_HALT_EN):
//   When the macro is defined, a captured word of 16'hFFFF is a halt opcode.
//   It is not presented to decode. Fetch freezes in HALT until reset.
//   When the macro is undefined, 16'hFFFF is an ordinary instruction and
//   halted is tied low.
//
// Parameters
//   RESET_VECTOR   first fetch address after reset
//
// Ports
//   clk            single clock, rising-edge state updates
//   reset          asynchronous, active-high reset
//   pc_addr        fetch address driven to the instruction memory
//   mem_instr      instruction memory read data (registered, 1-cycle latency)
//   stall          downstream not accepting; instr_valid && !stall = consumed
//   branch_taken   redirect request, sampled each edge
//   branch_target  redirect address
//   instr_out      fetched instruction to decode
//   instr_pc       address of instr_out
//   instr_valid    instr_out / instr_pc valid
//   halted         fetch stopped on halt opcode
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [7:0] RESET_VECTOR = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  output logic [7:0]  pc_addr,
  input  logic [15:0] mem_instr,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [7:0]  branch_target,
  output logic [15:0] instr_out,
  output logic [7:0]  instr_pc,
  output logic        instr_valid,
  output logic        halted
);

  // FILL : nothing in flight; the next edge launches pc_addr into memory.
  // RUN  : one word in flight; each accepted edge captures it and launches
  //        the next address.
  // STALL: decode holds a valid word. The in-flight word was dropped, and
  //        pc_addr was rewound to re-request it.
  // HALT : halt opcode seen; only reset leaves this state.
  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;
`ifdef FETCH_HALT_EN
  localparam logic [1:0] S_HALT  = 2'd3;
`endif

  logic [1:0]  state_q,       state_d;
  logic [7:0]  pc_addr_q,     pc_addr_d;
  logic [7:0]  if_pc_q,       if_pc_d;
  logic        if_valid_q,    if_valid_d;
  logic [15:0] instr_out_q,   instr_out_d;
  logic [7:0]  instr_pc_q,    instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
`ifdef FETCH_HALT_EN
  logic        halted_q,      halted_d;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first (hold its current
    // value). Then no path through the case leaves a signal unassigned, and
    // no latch is inferred.
    state_d       = state_q;
    pc_addr_d     = pc_addr_q;
    if_pc_d       = if_pc_q;
    if_valid_d    = if_valid_q;
    instr_out_d   = instr_out_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
`ifdef FETCH_HALT_EN
    halted_d      = halted_q;
`endif

    case (state_q)
      S_FILL: begin
        if (branch_taken) begin
          pc_addr_d     = branch_target;
          instr_valid_d = 1'b0;
          if_valid_d    = 1'b0;
          state_d       = S_FILL;
        end else begin
          // Memory samples pc_addr on this edge; remember which address that was.
          if_pc_d    = pc_addr_q;
          if_valid_d = 1'b1;
          pc_addr_d  = pc_addr_q + 8'd1;
          state_d    = S_RUN;
        end
      end

      S_RUN: begin
        if (branch_taken) begin
          // Redirect wins over stall; the word now on mem_instr is dropped.
          pc_addr_d     = branch_target;
          instr_valid_d = 1'b0;
          if_valid_d    = 1'b0;
          state_d       = S_FILL;
        end else if (stall && instr_valid_q) begin
          // Decode cannot take a new word, so the in-flight word has nowhere
          // to go. Rewind the fetch address to re-request it after the stall.
          pc_addr_d  = if_pc_q;
          if_valid_d = 1'b0;
          state_d    = S_STALL;
        end else if (if_valid_q) begin
`ifdef FETCH_HALT_EN
          if (mem_instr == 16'hFFFF) begin
            // Halt opcode: not presented; pc_addr stays where it is.
            instr_valid_d = 1'b0;
            halted_d      = 1'b1;
            state_d       = S_HALT;
          end else
`endif
          begin
            instr_out_d   = mem_instr;
            instr_pc_d    = if_pc_q;
            instr_valid_d = 1'b1;
            if_pc_d       = pc_addr_q;
            pc_addr_d     = pc_addr_q + 8'd1;
          end
        end
      end

      S_STALL: begin
        if (branch_taken) begin
          pc_addr_d     = branch_target;
          instr_valid_d = 1'b0;
          if_valid_d    = 1'b0;
          state_d       = S_FILL;
        end else if (!stall) begin
          // The held word is consumed on this edge. Memory samples pc_addr
          // (== if_pc) now, so if_pc is in flight again, and its data is
          // captured next cycle. That leaves a single bubble on instr_valid.
          instr_valid_d = 1'b0;
          if_valid_d    = 1'b1;
          pc_addr_d     = if_pc_q + 8'd1;
          state_d       = S_RUN;
        end
      end

`ifdef FETCH_HALT_EN
      S_HALT: begin
        // Frozen: branch_taken and stall have no effect here.
        state_d = S_HALT;
      end
`endif

      default: begin
        // Unreachable encodings recover through a clean refill.
        instr_valid_d = 1'b0;
        if_valid_d    = 1'b0;
        state_d       = S_FILL;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // update together from values sampled before the edge, regardless of the
  // order in which the simulator evaluates the statements.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_FILL;
      pc_addr_q     <= RESET_VECTOR;
      if_pc_q       <= 8'h00;
      if_valid_q    <= 1'b0;
      instr_out_q   <= 16'h0000;
      instr_pc_q    <= 8'h00;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_addr_q     <= pc_addr_d;
      if_pc_q       <= if_pc_d;
      if_valid_q    <= if_valid_d;
      instr_out_q   <= instr_out_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

`ifdef FETCH_HALT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) halted_q <= 1'b0;
    else       halted_q <= halted_d;
  end

  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  assign pc_addr     = pc_addr_q;
  assign instr_out   = instr_out_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter: RESET_VECTOR, 8'h00, first fetch address after reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: pc_addr  output  8  fetch address driven to the instruction memory.
REQ-005 SHALL have port: mem_instr  input  16  instruction memory read data (registered, 1-cycle latency).
REQ-006 SHALL have port: stall  input  1  downstream not accepting; instr_valid && !stall at an edge = consumed.
REQ-007 SHALL have port: branch_taken  input  1  redirect request, sampled each edge.
REQ-008 SHALL have port: branch_target  input  8  redirect address.
REQ-009 SHALL have port: instr_out  output  16  fetched instruction to decode.
REQ-010 SHALL have port: instr_pc  output  8  address of instr_out.
REQ-011 SHALL have port: instr_valid  output  1  instr_out/instr_pc valid.
REQ-012 SHALL have port: halted  output  1  fetch stopped on halt opcode.

Function
REQ-013 SHALL implement states FILL, RUN, STALL, HALT, with internal in-flight address if_pc and flag if_valid.
REQ-014 FILL (nothing in flight): on edge, memory samples pc_addr; SHALL set if_pc<=pc_addr, if_valid<=1, pc_addr<=pc_addr+1, go RUN.
REQ-015 RUN, !stall or !instr_valid: SHALL capture instr_out<=mem_instr, instr_pc<=if_pc, instr_valid<=1, then if_pc<=pc_addr, pc_addr<=pc_addr+1.
REQ-016 RUN, stall && instr_valid: SHALL hold instr_out/instr_pc/instr_valid, set pc_addr<=if_pc, if_valid<=0, go STALL.
REQ-017 STALL, stall held: SHALL hold all outputs and pc_addr (==if_pc).
REQ-018 STALL, stall released: SHALL set instr_valid<=0, if_valid<=1 (if_pc unchanged), pc_addr<=if_pc+1, go RUN.
REQ-019 Throughput SHALL be one instruction per cycle in RUN without stall; first instr_valid 2 edges after reset release.
REQ-020 branch_taken in FILL/RUN/STALL SHALL have priority over stall: pc_addr<=branch_target, instr_valid<=0, if_valid<=0, go FILL; the in-flight word is discarded.
REQ-021 pc_addr SHALL wrap 8'hFF -> 8'h00 modulo 256; instr_pc likewise.
REQ-022 No instruction SHALL be lost or duplicated across any stall/branch sequence; instr_pc sequence is contiguous except at branches.

Reset
REQ-023 reset SHALL asynchronously force state FILL, pc_addr=RESET_VECTOR, if_pc=0, if_valid=0, instr_out=16'h0000, instr_pc=8'h00, instr_valid=0, halted=0.
REQ-024 Reset mid-stall, mid-branch or in HALT SHALL discard all in-flight state; fetch restarts at RESET_VECTOR.

Configuration
REQ-025 Macro FETCH_HALT_EN defined: a captured mem_instr of 16'hFFFF in RUN SHALL not be presented; instead instr_valid<=0, halted<=1, pc_addr frozen, go HALT.
REQ-026 In HALT, branch_taken and stall SHALL be ignored; only reset exits.
REQ-027 Macro FETCH_HALT_EN undefined: 16'hFFFF SHALL be an ordinary instruction, HALT state absent, halted tied 0.

Verification
REQ-028 mem[0]=16'h1234, mem[1]=16'h5678, reset released, no stall -> instr_valid edge 2 with 1234/pc 00, next edge 5678/pc 01.
REQ-029 Stall high 3 cycles while instr_pc=01 valid -> 5678/01 held; after release 1 bubble, then instr_pc=02 with mem[2].
REQ-030 branch_taken with target 8'h40 in RUN -> instr_valid 0 for 2 edges, next valid instr_pc=40; in-flight word never appears.
REQ-031 branch_taken and stall both high in STALL -> branch wins, next valid instr_pc=branch_target.
REQ-032 RESET_VECTOR=8'hFE -> instr_pc sequence FE, FF, 00, 01.
REQ-033 FETCH_HALT_EN, mem[3]=16'hFFFF -> pc 00..02 delivered, halted=1, instr_valid stays 0; reset pulse clears halted, refetch from 00.
